// File: rtl/mem_responder_pkg.sv
// Shared definitions for the MEM-stage responder: FSM state codes,
// access-size encoding and the byte-lane helper functions used to
// place store data and extend load data.
package mem_responder_pkg;

    // Responder FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Access size encoding
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Byte wins over half when both are set; neither means a word access.
    function automatic size_e decode_size(input logic is_byte, input logic is_half);
        size_e sz;
        if (is_byte) begin
            sz = SIZE_BYTE;
        end else if (is_half) begin
            sz = SIZE_HALF;
        end else begin
            sz = SIZE_WORD;
        end
        return sz;
    endfunction

    // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        logic mis;
        case (sz)
            SIZE_HALF: mis = off[0];
            SIZE_WORD: mis = (off != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Little-endian lane enables for the addressed bytes.
    function automatic logic [3:0] byte_enable(input size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data is replicated across lanes; the enables pick
    // which copies actually land in memory.
    function automatic logic [31:0] place_wdata(input size_e sz, input logic [31:0] wdata);
        logic [31:0] w;
        case (sz)
            SIZE_BYTE: w = {4{wdata[7:0]}};
            SIZE_HALF: w = {2{wdata[15:0]}};
            SIZE_WORD: w = wdata;
            default:   w = 32'd0;
        endcase
        return w;
    endfunction

    // Select the addressed lane(s) of a memory word and sign/zero extend.
    function automatic logic [31:0] extend_load(input size_e sz, input logic [1:0] off,
                                                input logic is_unsigned, input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SIZE_BYTE: res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_HALF: res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            SIZE_WORD: res = word;
            default:   res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_mem_word_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Contents are deliberately not reset so data survives a responder reset.
module mem_word_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-lane write and registered read; the read register only changes on a read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// MEM-stage memory responder: accepts one load/store at a time, inserts a
// fixed number of wait states, then holds the response until it is taken.
// Memory is touched only on the edge that enters RESP, so a reset during
// the wait phase drops the access without side effects.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_byte,
    input  logic        req_half,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic        HAS_WAIT  = (WAIT_CYCLES != 0) ? 1'b1 : 1'b0;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]    r_state;
    logic [3:0]    r_wait_cnt;
    logic          r_write;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    size_e         r_size;
    logic          r_unsigned;
    logic          r_err;

    logic [1:0]    w_state_nxt;
    logic          w_accept;
    logic          w_enter_resp;
    logic          w_acc_write;
    logic [AW+1:0] w_acc_addr;
    logic [31:0]   w_acc_wdata;
    size_e         w_acc_size;
    logic          w_acc_misal;
    logic          w_mem_we;
    logic          w_mem_re;
    logic [31:0]   w_mem_rdata;
    logic          w_unused_addr;

    // Upper address bits are ignored so accesses wrap around the array.
    assign w_unused_addr = ^req_addr[31:AW+2];

    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_enter_resp = (w_accept && !HAS_WAIT) ||
                          ((r_state == ST_WAIT) && (r_wait_cnt == 4'd0));

    // Access attributes: live request in IDLE (zero-wait case), latched copy otherwise.
    always_comb begin
        w_acc_write = r_write;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        w_acc_size  = r_size;
        if (r_state == ST_IDLE) begin
            w_acc_write = req_write;
            w_acc_addr  = req_addr[AW+1:0];
            w_acc_wdata = req_wdata;
            w_acc_size  = decode_size(req_byte, req_half);
        end else begin
            w_acc_write = r_write;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
            w_acc_size  = r_size;
        end
    end

    assign w_acc_misal = is_misaligned(w_acc_size, w_acc_addr[1:0]);
    assign w_mem_we    = w_enter_resp && w_acc_write && !w_acc_misal;
    assign w_mem_re    = w_enter_resp && !w_acc_write && !w_acc_misal;

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_be    (byte_enable(w_acc_size, w_acc_addr[1:0])),
        .i_re    (w_mem_re),
        .i_addr  (w_acc_addr[AW+1:2]),
        .i_wdata (place_wdata(w_acc_size, w_acc_wdata)),
        .o_rdata (w_mem_rdata)
    );

    // Next-state decode for the IDLE/WAIT/RESP handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = HAS_WAIT ? ST_WAIT : ST_RESP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, wait counter, request latch and error flag.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_size     <= SIZE_WORD;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_write    <= req_write;
                r_addr     <= req_addr[AW+1:0];
                r_wdata    <= req_wdata;
                r_size     <= decode_size(req_byte, req_half);
                r_unsigned <= req_unsigned;
                r_wait_cnt <= WAIT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err <= w_acc_misal;
            end else if ((r_state == ST_RESP) && rsp_ready) begin
                r_err <= 1'b0;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = r_err;

    // Load data is valid only for error-free loads in RESP; everything else reads 0.
    always_comb begin
        rsp_rdata = 32'd0;
        if ((r_state == ST_RESP) && !r_write && !r_err) begin
            rsp_rdata = extend_load(r_size, r_addr[1:0], r_unsigned, w_mem_rdata);
        end else begin
            rsp_rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default parameters
// (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        CLR;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_byte;
    logic        req_half;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder dut (
        .clk          (clk),
        .CLR          (CLR),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_byte     (req_byte),
        .req_half     (req_half),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Drive one request, measure cycles from the accepting cycle to rsp_valid,
    // capture the response and complete the handshake. Called #1 after an edge.
    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic b, input logic h, input logic u,
                             output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wdata;
        req_byte     = b;
        req_half     = h;
        req_unsigned = u;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          guard;

        CLR = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_byte = 1'b0; req_half = 1'b0; req_unsigned = 1'b0; rsp_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        CLR = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Word store then load, latency WAIT_CYCLES+1 = 3
        do_access(1'b1, 32'h10, 32'h11223344, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("st_w10_lat",   32'(lat), 32'd3);
        chk("st_w10_err",   {31'd0, er}, 32'd0);
        chk("st_w10_rdata", rd, 32'd0);
        do_access(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("ld_w10_lat",   32'(lat), 32'd3);
        chk("ld_w10_err",   {31'd0, er}, 32'd0);
        chk("ld_w10_rdata", rd, 32'h11223344);

        // Byte store into lane 2, signed/unsigned byte loads, word read-back
        do_access(1'b1, 32'h12, 32'h000000AB, 1'b1, 1'b0, 1'b0, rd, er, lat);
        chk("st_b12_err", {31'd0, er}, 32'd0);
        do_access(1'b0, 32'h12, 32'd0, 1'b1, 1'b0, 1'b0, rd, er, lat);
        chk("ld_sb12", rd, 32'hFFFFFFAB);
        do_access(1'b0, 32'h12, 32'd0, 1'b1, 1'b0, 1'b1, rd, er, lat);
        chk("ld_ub12", rd, 32'h000000AB);
        do_access(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("ld_w10_after_b", rd, 32'h11AB3344);
        // byte+half together is a byte access: lane 1 of 0x11AB3344 is 0x33
        do_access(1'b0, 32'h11, 32'd0, 1'b1, 1'b1, 1'b1, rd, er, lat);
        chk("ld_bh11_err", {31'd0, er}, 32'd0);
        chk("ld_bh11",     rd, 32'h00000033);

        // Misaligned accesses
        do_access(1'b0, 32'h11, 32'd0, 1'b0, 1'b1, 1'b0, rd, er, lat);
        chk("ld_h11_err",   {31'd0, er}, 32'd1);
        chk("ld_h11_rdata", rd, 32'd0);
        do_access(1'b1, 32'h14, 32'h55667788, 1'b0, 1'b0, 1'b0, rd, er, lat);
        do_access(1'b1, 32'h16, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("st_w16_err", {31'd0, er}, 32'd1);
        do_access(1'b0, 32'h14, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("ld_w14_unchanged", rd, 32'h55667788);

        // Upper-half store and signed/unsigned half loads
        do_access(1'b1, 32'h16, 32'h12348001, 1'b0, 1'b1, 1'b0, rd, er, lat);
        do_access(1'b0, 32'h16, 32'd0, 1'b0, 1'b1, 1'b0, rd, er, lat);
        chk("ld_sh16", rd, 32'hFFFF8001);
        do_access(1'b0, 32'h16, 32'd0, 1'b0, 1'b1, 1'b1, rd, er, lat);
        chk("ld_uh16", rd, 32'h00008001);
        do_access(1'b0, 32'h14, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("ld_w14_after_h", rd, 32'h80017788);

        // Response back-pressure
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        req_byte = 1'b0; req_half = 1'b0; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("bp_reached_resp", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h11AB3344);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("bp_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);

        // Reset during WAIT abandons the store
        do_access(1'b1, 32'h20, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("clr_in_wait", {31'd0, req_ready}, 32'd0);
        CLR = 1'b1;
        #1;
        chk("clr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("clr_rsp_rdata", rsp_rdata, 32'd0);
        chk("clr_rsp_err",   {31'd0, rsp_err}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        CLR = 1'b0;
        @(posedge clk); #1;
        chk("clr_req_ready", {31'd0, req_ready}, 32'd1);
        do_access(1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("ld_w20_prior", rd, 32'h0BADF00D);
        // Storage survives reset
        do_access(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("ld_w10_post_clr", rd, 32'h11AB3344);

        // Address wrap-around at DEPTH_WORDS*4
        do_access(1'b1, 32'h0, 32'h76543210, 1'b0, 1'b0, 1'b0, rd, er, lat);
        do_access(1'b0, 32'h1000, 32'd0, 1'b0, 1'b0, 1'b0, rd, er, lat);
        chk("ld_wrap_1000", rd, 32'h76543210);
        chk("ld_wrap_err",  {31'd0, er}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
